instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Program-sequencing reader for the instruction memory. Drives address/programSelect into the
//   combinational instruction ROM, captures the returned 16-bit word into an output register and
//   hands it to the decoder over a valid/ready handshake. Owns the PC, applies branch redirects,
//   and stops on HALT or on an out-of-range fetch. Sits between instruction memory and decode.
// PARAMETERS
//   MEM_DEPTH   128       words per program image; legal PC range 0..MEM_DEPTH-1
//   HALT_OPCODE 4'b1111   value of instruction[15:12] that terminates fetch
//   START_PC    8'd0      PC loaded on start
// PORTS
//   clk             in   1   single clock; all state updates on rising edge
//   rst_n           in   1   asynchronous, active-low reset
//   start           in   1   pulse: begin fetching program programSelectIn from START_PC
//   programSelectIn in   2   program image chosen at start (00..11)
//   programSelect   out  2   to instruction memory; latched copy of programSelectIn
//   address         out  8   to instruction memory; equals current PC
//   instruction     in   16  from instruction memory; valid combinationally in same cycle as address
//   instrOut        out  16  captured instruction to decoder
//   instrPc         out  8   PC of instrOut
//   instrValid      out  1   instrOut/instrPc valid
//   instrReady      in   1   decoder accepts when instrValid & instrReady
//   redirect        in   1   branch taken; one-cycle pulse
//   redirectTarget  in   8   new PC when redirect
//   busy            out  1   high in FETCH or DRAIN
//   halted          out  1   sticky: HALT word accepted by decoder
//   fault           out  1   sticky: PC or redirectTarget >= MEM_DEPTH
// BEHAVIOUR
//   Reset (async, any time incl. mid-fetch): state=IDLE, PC=START_PC, programSelect=0,
//     instrOut=0, instrPc=0, instrValid=0, halted=0, fault=0, busy=0. address tracks PC.
//   States: IDLE, FETCH, DRAIN, DONE.
//   IDLE: start -> latch programSelectIn, PC<=START_PC, clear halted/fault, go FETCH.
//   FETCH: "slot free" = !instrValid | instrReady. When slot free and no redirect:
//     instrOut<=instruction, instrPc<=PC, instrValid<=1, PC<=PC+1 (8-bit).
//     Captured word with [15:12]==HALT_OPCODE -> go DRAIN, PC frozen.
//     If PC+1 == MEM_DEPTH after a non-HALT capture -> go DRAIN with fault pending.
//     Slot not free -> hold everything (stall), PC unchanged.
//   Throughput: one instruction per cycle with instrReady held high; first instrValid one cycle
//     after start.
//   redirect (FETCH only; ignored in other states): PC<=redirectTarget, instrValid<=0 (flush
//     held word even if instrReady same cycle; the handshake still counts as accepted), no capture
//     that cycle. redirectTarget >= MEM_DEPTH -> fault<=1, go DONE. redirect beats stall and HALT.
//   DRAIN: no further captures; when instrValid & instrReady -> instrValid<=0, go DONE; set
//     halted if word was HALT, else set fault.
//   DONE: busy=0; holds halted/fault; start re-launches as from IDLE.
//   start while busy: ignored. Simultaneous start and redirect in IDLE/DONE: start wins.
//   busy = (state==FETCH)|(state==DRAIN). halted and fault never both set.
// STRUCTURE
//   Shared package fetch_pkg: state enum fetch_state_t, OPCODE_W=4, INSTR_W=16, ADDR_W=8,
//     HALT_OPCODE constant (also used by decoder).
//   One sub-module: fetch_out_reg (instrOut/instrPc/instrValid holding register with load, flush
//     and handshake-clear); FSM and PC live in the top.
// TESTING
//   1 start, sel=01, ROM words 0..3 = 0x2001,0x2002,0x2003,0xF000, ready=1 -> instrOut 0x2001..0xF000
//     on 4 consecutive cycles, instrPc 0..3, halted=1 after 4th accept, busy=0.
//   2 ready low cycles 2-4 of run -> instrOut/instrPc held stable, PC held, no word lost or duplicated.
//   3 redirect to 0x10 while instrValid & !instrReady at PC 2 -> held word dropped, next
//     instrPc=0x10; redirect to 0x90 (>=128) -> fault=1, DONE, no valid issued.
//   4 program with no HALT, ready=1 -> instrPc 0..127, then fault=1, halted=0, PC not wrapped.
//   5 rst_n low mid-FETCH (async, between edges) -> all outputs reset immediately; start ignored
//     while busy; start after DONE restarts at START_PC with new programSelect.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: widths, HALT opcode and the fetch FSM state type.
package fetch_pkg;
  localparam int OPCODE_W = 4;
  localparam int INSTR_W  = 16;
  localparam int ADDR_W   = 8;

  localparam logic [OPCODE_W-1:0] HALT_OPCODE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word,
                                   input logic [OPCODE_W-1:0] opcode);
    return word[INSTR_W-1 -: OPCODE_W] == opcode;
  endfunction
endpackage

// File: rtl/fetch_out_reg.sv
// Holding register for the word handed to decode; flush beats load, load beats handshake-clear.
module fetch_out_reg #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              flush,
  input  logic [DATA_W-1:0] data_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              ready,
  output logic [DATA_W-1:0] data,
  output logic [ADDR_W-1:0] pc,
  output logic              valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data  <= '0;
      pc    <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      data  <= data_in;
      pc    <= pc_in;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, reads the combinational ROM, issues words to decode
// over valid/ready, applies branch redirects and stops on HALT or out-of-range fetch.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    MEM_DEPTH   = 128,
  parameter logic [OPCODE_W-1:0]   HALT_OPCODE = fetch_pkg::HALT_OPCODE,
  parameter logic [ADDR_W-1:0]     START_PC    = 8'd0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          programSelectIn,
  output logic [1:0]          programSelect,
  output logic [ADDR_W-1:0]   address,
  input  logic [INSTR_W-1:0]  instruction,
  output logic [INSTR_W-1:0]  instrOut,
  output logic [ADDR_W-1:0]   instrPc,
  output logic                instrValid,
  input  logic                instrReady,
  input  logic                redirect,
  input  logic [ADDR_W-1:0]   redirectTarget,
  output logic                busy,
  output logic                halted,
  output logic                fault
);
  // One extra bit so a depth equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W+1)'(MEM_DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        prog_sel;
  logic              halted_q;
  logic              fault_q;

  logic slot_free, in_fetch, do_load, do_flush, cap_halt, last_word, target_bad;

  assign in_fetch   = (state == ST_FETCH);
  assign slot_free  = !instrValid || instrReady;
  assign do_flush   = in_fetch && redirect;
  assign do_load    = in_fetch && !redirect && slot_free;
  assign cap_halt   = is_halt(instruction, HALT_OPCODE);
  assign last_word  = ({1'b0, pc} + 1'b1) == DEPTH;
  assign target_bad = {1'b0, redirectTarget} >= DEPTH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      pc       <= START_PC;
      prog_sel <= 2'b00;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            prog_sel <= programSelectIn;
            pc       <= START_PC;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (redirect) begin
            pc <= redirectTarget;
            if (target_bad) begin
              fault_q <= 1'b1;
              state   <= ST_DONE;
            end
          end else if (slot_free) begin
            // A HALT word freezes the PC at its own address.
            if (cap_halt) begin
              state <= ST_DRAIN;
            end else begin
              pc <= pc + 1'b1;
              if (last_word) state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (instrValid && instrReady) begin
            state <= ST_DONE;
            if (is_halt(instrOut, HALT_OPCODE)) halted_q <= 1'b1;
            else                                 fault_q  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fetch_out_reg #(
    .DATA_W (INSTR_W),
    .ADDR_W (ADDR_W)
  ) u_out_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (do_load),
    .flush   (do_flush),
    .data_in (instruction),
    .pc_in   (pc),
    .ready   (instrReady),
    .data    (instrOut),
    .pc      (instrPc),
    .valid   (instrValid)
  );

  assign address       = pc;
  assign programSelect = prog_sel;
  assign busy          = (state == ST_FETCH) || (state == ST_DRAIN);
  assign halted        = halted_q;
  assign fault         = fault_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table-driven cycle vectors plus hand sequences.
module tb_instruction_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  programSelectIn;
  logic [1:0]  programSelect;
  logic [7:0]  address;
  logic [15:0] instruction;
  logic [15:0] instrOut;
  logic [7:0]  instrPc;
  logic        instrValid;
  logic        instrReady;
  logic        redirect;
  logic [7:0]  redirectTarget;
  logic        busy, halted, fault;

  int total = 0;
  int bad   = 0;

  logic [15:0] rom [4][256];
  assign instruction = rom[programSelect][address];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .programSelectIn(programSelectIn),
    .programSelect(programSelect), .address(address), .instruction(instruction),
    .instrOut(instrOut), .instrPc(instrPc), .instrValid(instrValid), .instrReady(instrReady),
    .redirect(redirect), .redirectTarget(redirectTarget), .busy(busy), .halted(halted),
    .fault(fault)
  );

  typedef struct {
    logic        start;
    logic [1:0]  sel;
    logic        ready;
    logic        redir;
    logic [7:0]  tgt;
    logic        v;
    logic [15:0] out;
    logic [7:0]  ipc;
    logic [7:0]  addr;
    logic        busy;
    logic        halted;
    logic        fault;
  } vec_t;

  function automatic vec_t mk(input logic st, input logic [1:0] sel, input logic rdy,
                              input logic rd, input logic [7:0] tg, input logic v,
                              input logic [15:0] o, input logic [7:0] ip, input logic [7:0] ad,
                              input logic b, input logic h, input logic f);
    vec_t r;
    r.start = st; r.sel = sel; r.ready = rdy; r.redir = rd; r.tgt = tg;
    r.v = v; r.out = o; r.ipc = ip; r.addr = ad; r.busy = b; r.halted = h; r.fault = f;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each entry: outputs expected this cycle, then inputs driven for the coming edge.
  task automatic run_tbl(input string tag, input vec_t t[$]);
    for (int i = 0; i < t.size(); i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s[%0d].valid",  tag, i), 32'(instrValid), 32'(t[i].v));
      chk($sformatf("%s[%0d].instr",  tag, i), 32'(instrOut),   32'(t[i].out));
      chk($sformatf("%s[%0d].ipc",    tag, i), 32'(instrPc),    32'(t[i].ipc));
      chk($sformatf("%s[%0d].addr",   tag, i), 32'(address),    32'(t[i].addr));
      chk($sformatf("%s[%0d].busy",   tag, i), 32'(busy),       32'(t[i].busy));
      chk($sformatf("%s[%0d].halted", tag, i), 32'(halted),     32'(t[i].halted));
      chk($sformatf("%s[%0d].fault",  tag, i), 32'(fault),      32'(t[i].fault));
      start           = t[i].start;
      programSelectIn = t[i].sel;
      instrReady      = t[i].ready;
      redirect        = t[i].redir;
      redirectTarget  = t[i].tgt;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".valid"},  32'(instrValid),    0);
    chk({tag, ".instr"},  32'(instrOut),      0);
    chk({tag, ".ipc"},    32'(instrPc),       0);
    chk({tag, ".addr"},   32'(address),       0);
    chk({tag, ".sel"},    32'(programSelect), 0);
    chk({tag, ".busy"},   32'(busy),          0);
    chk({tag, ".halted"}, 32'(halted),        0);
    chk({tag, ".fault"},  32'(fault),         0);
  endtask

  vec_t t1[$], t2[$], t3[$];

  initial begin
    int cyc;
    for (int p = 0; p < 4; p++)
      for (int a = 0; a < 256; a++) rom[p][a] = 16'h0000;
    for (int a = 0; a < 256; a++) begin
      rom[0][a] = 16'h3000 + 16'(a);
      rom[2][a] = 16'h1000 | 16'(a);
      rom[3][a] = 16'h4000 + 16'(a);
    end
    rom[0][20] = 16'hF000;
    rom[1][0] = 16'h2001; rom[1][1] = 16'h2002; rom[1][2] = 16'h2003; rom[1][3] = 16'hF000;
    rom[3][10] = 16'hF00A;

    // basic run to HALT with ready held high
    t1.push_back(mk(1,1,1,0,0,     0,16'h0000,0,0, 0,0,0));
    t1.push_back(mk(0,1,1,0,0,     0,16'h0000,0,0, 1,0,0));
    t1.push_back(mk(0,1,1,0,0,     1,16'h2001,0,1, 1,0,0));
    t1.push_back(mk(0,1,1,0,0,     1,16'h2002,1,2, 1,0,0));
    t1.push_back(mk(0,1,1,0,0,     1,16'h2003,2,3, 1,0,0));
    t1.push_back(mk(0,1,1,0,0,     1,16'hF000,3,3, 1,0,0));
    t1.push_back(mk(0,1,1,0,0,     0,16'hF000,3,3, 0,1,0));
    // restart from DONE with decoder stalled for three cycles
    t2.push_back(mk(1,1,1,0,0,     0,16'hF000,3,3, 0,1,0));
    t2.push_back(mk(0,1,1,0,0,     0,16'hF000,3,0, 1,0,0));
    t2.push_back(mk(0,1,0,0,0,     1,16'h2001,0,1, 1,0,0));
    t2.push_back(mk(0,1,0,0,0,     1,16'h2001,0,1, 1,0,0));
    t2.push_back(mk(0,1,0,0,0,     1,16'h2001,0,1, 1,0,0));
    t2.push_back(mk(0,1,1,0,0,     1,16'h2001,0,1, 1,0,0));
    t2.push_back(mk(0,1,1,0,0,     1,16'h2002,1,2, 1,0,0));
    t2.push_back(mk(0,1,1,0,0,     1,16'h2003,2,3, 1,0,0));
    t2.push_back(mk(0,1,1,0,0,     1,16'hF000,3,3, 1,0,0));
    t2.push_back(mk(0,1,1,0,0,     0,16'hF000,3,3, 0,1,0));
    // redirect over a stalled word, then an out-of-range redirect, then one ignored in DONE
    t3.push_back(mk(1,0,1,0,0,     0,16'hF000,3,3, 0,1,0));
    t3.push_back(mk(0,0,1,0,0,     0,16'hF000,3,0, 1,0,0));
    t3.push_back(mk(0,0,1,0,0,     1,16'h3000,0,1, 1,0,0));
    t3.push_back(mk(0,0,0,1,8'h10, 1,16'h3001,1,2, 1,0,0));
    t3.push_back(mk(0,0,1,0,0,     0,16'h3001,1,8'h10, 1,0,0));
    t3.push_back(mk(0,0,0,1,8'h90, 1,16'h3010,8'h10,8'h11, 1,0,0));
    t3.push_back(mk(0,0,1,1,8'h05, 0,16'h3010,8'h10,8'h90, 0,0,1));
    t3.push_back(mk(0,0,1,0,0,     0,16'h3010,8'h10,8'h90, 0,0,1));

    rst_n = 1'b0; start = 1'b0; programSelectIn = 2'b00; instrReady = 1'b1;
    redirect = 1'b0; redirectTarget = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    run_tbl("t1", t1);
    run_tbl("t2", t2);
    run_tbl("t3", t3);

    // no HALT in image: 128 words then fault, PC parked at MEM_DEPTH
    @(posedge clk); #1;
    start = 1'b1; programSelectIn = 2'd2; instrReady = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t4.busy_at_start", 32'(busy), 1);
    chk("t4.fault_cleared", 32'(fault), 0);
    for (int i = 0; i < 128; i++) begin
      @(posedge clk); #1;
      chk($sformatf("t4.word%0d", i),
          {15'(0), instrValid, instrPc, instrOut},
          {15'(0), 1'b1, 8'(i), 16'h1000 | 16'(i)});
    end
    @(posedge clk); #1;
    chk("t4.fault",  32'(fault),      1);
    chk("t4.halted", 32'(halted),     0);
    chk("t4.busy",   32'(busy),       0);
    chk("t4.valid",  32'(instrValid), 0);
    chk("t4.addr",   32'(address),    32'h80);

    // async reset mid-fetch; start ignored while busy
    start = 1'b1; programSelectIn = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("t5.first_pc", 32'(instrPc), 0);
    start = 1'b1; programSelectIn = 2'd2;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5.busy_start_sel", 32'(programSelect), 3);
    chk("t5.busy_start_ipc", 32'(instrPc), 1);
    chk("t5.busy_start_adr", 32'(address), 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("t5.async");
    @(posedge clk); #1;
    chk_reset_outputs("t5.held");
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; programSelectIn = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (busy && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("t5.run_timeout", 32'(busy),    0);
    chk("t5.halted",      32'(halted),  1);
    chk("t5.halt_pc",     32'(instrPc), 10);
    chk("t5.halt_word",   32'(instrOut), 32'hF00A);
    start = 1'b1; programSelectIn = 2'd1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t5.restart_sel",    32'(programSelect), 1);
    chk("t5.restart_addr",   32'(address), 0);
    chk("t5.restart_halted", 32'(halted), 0);
    @(posedge clk); #1;
    chk("t5.restart_word", {15'(0), instrValid, instrPc, instrOut}, {15'(0), 1'b1, 8'd0, 16'h2001});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
